// File: rtl/chip8_memory.sv
// chip8_memory: 4 KiB byte RAM serving chip8_cpu.
// After reset it writes the hex font to 0x000-0x04F, then takes a program
// image over a valid/ready byte stream at PROG_BASE, then releases the CPU.
//
// Load handshake: a byte transfers on every rising edge where
// load_valid && load_ready are both high; load_ready is high exactly while
// the FSM is in LOAD, and load_data/load_last are qualified by load_valid.
module chip8_memory #(
    parameter logic [11:0] PROG_BASE  = 12'h200,
    parameter int          FONT_BYTES = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] cpu_addr,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  rd_data,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic [11:0] load_count,
    output logic        load_overflow,
    output logic        wp_violation,
    output logic        cpu_reset,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_FONT = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [11:0] FONT_LIMIT = 12'(FONT_BYTES);
    localparam logic [6:0]  FONT_LAST  = 7'(FONT_BYTES - 1);

    // Standard CHIP-8 hex font, digit 0 in the most significant bytes.
    localparam logic [639:0] FONT_FLAT = {
        40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
        40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
        40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
        40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
    };

    state_t      state;
    logic [6:0]  font_idx;
    logic [9:0]  font_sel;
    logic [7:0]  font_byte;
    logic [7:0]  ram [4096];

    logic [12:0] load_addr_ext;
    logic        load_fits;
    logic        load_fire;
    logic        cpu_wr_ok;
    logic        cpu_wr_bad;

    logic        ram_we;
    logic [11:0] ram_waddr;
    logic [7:0]  ram_wdata;

    // cpu_read carries no information here: reads are combinational on cpu_addr.
    logic        unused_cpu_read;
    assign unused_cpu_read = cpu_read;

    assign font_sel  = {3'b000, FONT_LAST - font_idx} << 3;
    assign font_byte = FONT_FLAT[font_sel +: 8];

    // One extra bit so an address past 0xFFF shows up instead of wrapping.
    assign load_addr_ext = {1'b0, PROG_BASE} + {1'b0, load_count};
    assign load_fits     = ~load_addr_ext[12];
    // load_start beats a coincident handshake, so the byte is discarded.
    assign load_fire     = (state == S_LOAD) && load_valid && !load_start;

    // A restart in RUN takes priority over a coincident CPU write.
    assign cpu_wr_ok  = (state == S_RUN) && cpu_write && !load_start && (cpu_addr >= FONT_LIMIT);
    assign cpu_wr_bad = (state == S_RUN) && cpu_write && !load_start && (cpu_addr <  FONT_LIMIT);

    assign load_ready = (state == S_LOAD);
    assign state_dbg  = state;
    assign rd_data    = (state == S_RUN) ? ram[cpu_addr] : 8'h00;

    // Select the single RAM write source for this cycle from the FSM state.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = 12'h000;
        ram_wdata = 8'h00;
        case (state)
            S_FONT: begin
                ram_we    = 1'b1;
                ram_waddr = {5'b00000, font_idx};
                ram_wdata = font_byte;
            end
            S_LOAD: begin
                ram_we    = load_fire && load_fits;
                ram_waddr = load_addr_ext[11:0];
                ram_wdata = load_data;
            end
            S_RUN: begin
                ram_we    = cpu_wr_ok;
                ram_waddr = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            default: ram_we = 1'b0;
        endcase
        if (reset) begin
            ram_we = 1'b0;
        end
    end

    // RAM storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Control FSM: font fill, program load, then run with write protection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_FONT;
            font_idx      <= 7'd0;
            load_count    <= 12'd0;
            load_overflow <= 1'b0;
            wp_violation  <= 1'b0;
            cpu_reset     <= 1'b1;
        end else begin
            case (state)
                S_FONT: begin
                    font_idx <= font_idx + 7'd1;
                    if (font_idx == FONT_LAST) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        load_count <= 12'd0;
                    end else if (load_valid) begin
                        if (load_fits) begin
                            load_count <= load_count + 12'd1;
                        end else begin
                            load_overflow <= 1'b1;
                        end
                        if (load_last) begin
                            state     <= S_RUN;
                            cpu_reset <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (load_start) begin
                        state         <= S_LOAD;
                        load_count    <= 12'd0;
                        load_overflow <= 1'b0;
                        wp_violation  <= 1'b0;
                        cpu_reset     <= 1'b1;
                    end else if (cpu_wr_bad) begin
                        wp_violation <= 1'b1;
                    end
                end
                default: state <= S_FONT;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_memory.sv
// Directed bench for chip8_memory: font fill timing and content, program
// load handshake, CPU read/write with font write protection, overflow,
// restart behaviour and asynchronous reset in every phase.
module tb_chip8_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  rd_data;
    logic        load_start;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic [11:0] load_count;
    logic        load_overflow;
    logic        wp_violation;
    logic        cpu_reset;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] font_exp [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    logic [7:0] six_bytes [6] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    chip8_memory dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_wdata     (cpu_wdata),
        .rd_data       (rd_data),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_count    (load_count),
        .load_overflow (load_overflow),
        .wp_violation  (wp_violation),
        .cpu_reset     (cpu_reset),
        .state_dbg     (state_dbg)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        tick();
        cpu_write = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [7:0] exp);
        cpu_addr = a;
        cpu_read = 1'b1;
        #1;
        check(tag, 16'(rd_data), 16'(exp));
        cpu_read = 1'b0;
    endtask

    // Reset released 1 ns after an edge; that edge counts as edge 1, so the
    // font occupies the next 80 edges and load_ready rises on edge 81.
    task automatic release_and_fill(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (79) tick();
        check({tag, "_ready_before_81"}, 16'(load_ready), 16'h0000);
        check({tag, "_state_font"},      16'(state_dbg),  16'h0000);
        tick();
        check({tag, "_ready_at_81"},     16'(load_ready), 16'h0001);
        check({tag, "_state_load"},      16'(state_dbg),  16'h0001);
    endtask

    // Directed stimulus and scoreboard
    initial begin
        reset      = 1'b1;
        cpu_addr   = 12'h000;
        cpu_read   = 1'b0;
        cpu_write  = 1'b0;
        cpu_wdata  = 8'h00;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
        repeat (2) tick();

        check("rst_load_ready", 16'(load_ready),    16'h0000);
        check("rst_cpu_reset",  16'(cpu_reset),     16'h0001);
        check("rst_rd_data",    16'(rd_data),       16'h0000);
        check("rst_load_count", 16'(load_count),    16'h0000);
        check("rst_overflow",   16'(load_overflow), 16'h0000);
        check("rst_wp",         16'(wp_violation),  16'h0000);
        check("rst_state",      16'(state_dbg),     16'h0000);

        // CPU strobes and load_start are ignored during FONT.
        cpu_addr  = 12'h010;
        cpu_wdata = 8'hEE;
        cpu_write = 1'b1;
        load_start = 1'b1;
        release_and_fill("boot");
        cpu_write  = 1'b0;
        load_start = 1'b0;
        check("load_rd_zero", 16'(rd_data), 16'h0000);

        // Two-byte image.
        send_byte(8'h11, 1'b0);
        check("two_cpu_reset_held", 16'(cpu_reset), 16'h0001);
        send_byte(8'h22, 1'b1);
        check("two_state_run", 16'(state_dbg),  16'h0002);
        check("two_cpu_reset", 16'(cpu_reset),  16'h0000);
        check("two_count",     16'(load_count), 16'h0002);
        check("two_ready_low", 16'(load_ready), 16'h0000);
        for (int i = 0; i < 5; i++) begin
            rd_check($sformatf("font_lo_%0d", i), 12'(i), font_exp[i]);
            rd_check($sformatf("font_hi_%0d", 75 + i), 12'(75 + i), font_exp[75 + i]);
        end
        rd_check("two_b0", 12'h200, 8'h11);
        rd_check("two_b1", 12'h201, 8'h22);

        // Restart from RUN, then six bytes with valid toggling.
        pulse_start();
        check("rs1_cpu_reset", 16'(cpu_reset),  16'h0001);
        check("rs1_count",     16'(load_count), 16'h0000);
        check("rs1_state",     16'(state_dbg),  16'h0001);
        for (int i = 0; i < 5; i++) begin
            send_byte(six_bytes[i], 1'b0);
            tick();
        end
        check("six_count5",     16'(load_count), 16'h0005);
        check("six_reset_held", 16'(cpu_reset),  16'h0001);
        send_byte(six_bytes[5], 1'b1);
        check("six_reset_fell", 16'(cpu_reset),  16'h0000);
        check("six_count",      16'(load_count), 16'h0006);
        for (int i = 0; i < 6; i++) begin
            rd_check($sformatf("six_rd_%0d", i), 12'(12'h200 + i), six_bytes[i]);
        end

        // CPU writes in RUN.
        cpu_wr(12'h300, 8'hAB);
        rd_check("wr_300", 12'h300, 8'hAB);
        cpu_addr  = 12'h300;
        cpu_wdata = 8'hCD;
        cpu_write = 1'b1;
        cpu_read  = 1'b1;
        #1;
        check("rw_old_value", 16'(rd_data), 16'h00AB);
        tick();
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        check("rw_new_value", 16'(rd_data), 16'h00CD);
        cpu_wr(12'h301, 8'h01);
        cpu_wr(12'h302, 8'h02);
        cpu_wr(12'h303, 8'h05);
        rd_check("bcd_0", 12'h301, 8'h01);
        rd_check("bcd_1", 12'h302, 8'h02);
        rd_check("bcd_2", 12'h303, 8'h05);
        check("wp_clear", 16'(wp_violation), 16'h0000);
        cpu_wr(12'h010, 8'h55);
        rd_check("wp_010_kept", 12'h010, 8'h10);
        check("wp_set", 16'(wp_violation), 16'h0001);
        cpu_wr(12'h04F, 8'h66);
        rd_check("wp_04f_kept", 12'h04F, 8'h80);
        cpu_wr(12'h050, 8'h77);
        rd_check("wr_050", 12'h050, 8'h77);
        check("wp_sticky", 16'(wp_violation), 16'h0001);

        // Restart clears flags; load_start beats a coincident byte.
        pulse_start();
        check("rs2_wp",        16'(wp_violation), 16'h0000);
        check("rs2_cpu_reset", 16'(cpu_reset),    16'h0001);
        check("rs2_count",     16'(load_count),   16'h0000);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        load_last  = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("start_wins_count", 16'(load_count), 16'h0000);
        check("start_wins_state", 16'(state_dbg),  16'h0001);

        // Fill 0x200-0xFFF, then one byte too many.
        for (int i = 0; i < 3584; i++) begin
            send_byte(8'(i * 7 + 3), 1'b0);
        end
        check("full_count",    16'(load_count),    16'h0E00);
        check("full_overflow", 16'(load_overflow), 16'h0000);
        send_byte(8'hFF, 1'b1);
        check("ovf_flag",  16'(load_overflow), 16'h0001);
        check("ovf_count", 16'(load_count),    16'h0E00);
        check("ovf_state", 16'(state_dbg),     16'h0002);
        rd_check("ovf_200",  12'h200, 8'h03);
        rd_check("ovf_201",  12'h201, 8'h0A);
        rd_check("ovf_fff",  12'hFFF, 8'hFC);
        rd_check("ovf_font", 12'h000, 8'hF0);
        pulse_start();
        check("rs3_overflow", 16'(load_overflow), 16'h0000);

        // Asynchronous reset in the middle of LOAD.
        send_byte(8'h42, 1'b0);
        check("mid_load_count", 16'(load_count), 16'h0001);
        #2;
        reset = 1'b1;
        #1;
        check("rst_load_ready",  16'(load_ready), 16'h0000);
        check("rst_load_cpurst", 16'(cpu_reset),  16'h0001);
        check("rst_load_count",  16'(load_count), 16'h0000);

        // Asynchronous reset at font index 40, then a full refill.
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) tick();
        check("font40_state", 16'(state_dbg), 16'h0000);
        #2;
        reset = 1'b1;
        #1;
        check("font40_rst_state", 16'(state_dbg), 16'h0000);
        release_and_fill("refill");
        send_byte(8'h99, 1'b1);
        check("refill_run", 16'(state_dbg), 16'h0002);
        for (int i = 0; i < 80; i++) begin
            rd_check($sformatf("refill_font_%0d", i), 12'(i), font_exp[i]);
        end
        rd_check("refill_200", 12'h200, 8'h99);

        // Asynchronous reset in the middle of RUN.
        cpu_addr = 12'h200;
        #2;
        reset = 1'b1;
        #1;
        check("rst_run_cpu_reset", 16'(cpu_reset), 16'h0001);
        check("rst_run_rd_data",   16'(rd_data),   16'h0000);
        check("rst_run_ready",     16'(load_ready), 16'h0000);
        repeat (2) tick();

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
